float_acc_e4m3: RTL
===================

# float_acc_e4m3

- Streaming reduction stage that sums a packet of e4m3 values into one e4m3 result.
- Feeds the combinational e4m3 adder (`float_adder_e4m3`, one instance) with the running accumulator and the incoming element, and registers the adder's result back into the accumulator.
- Packets arrive on a valid/ready input stream delimited by `in_last`; the reduced value and element count leave on a valid/ready output stream.
- Sits between an operand producer (e.g. a dot-product lane) and any consumer of scalar e4m3 results.

## Interface
- `LEN_W`, default 8: width of the element counter and `out_count`.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: block can accept a beat.
- `in_data` input 8: e4m3 element, {sign, exp[3:0], man[2:0]}.
- `in_last` input 1: beat is the final element of the packet.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output 8: e4m3 sum of the packet.
- `out_count` output LEN_W: number of elements in the packet, saturating at 2^LEN_W-1.

## Operation
- A beat is accepted when `in_valid && in_ready`; a result is taken when `out_valid && out_ready`.
- States:
  - IDLE: `in_ready`=1. An accepted beat loads `acc <= in_data` directly, with no pass through the adder, so a single-element packet is bit-exact. Sets `cnt <= 1`. Goes to OUT if `in_last`, else ACC.
  - ACC: `in_ready`=1. An accepted beat sets `acc <= adder(acc, in_data)` and `cnt <= sat(cnt+1)`. Goes to OUT if `in_last`.
  - OUT: `in_ready`=0 and `out_valid`=1. `out_data`=`acc` and `out_count`=`cnt`, both held stable until taken. On take, goes to IDLE.
- The adder is driven with `acc` as operand a and `in_data` as operand b. Its 8-bit result is used unmodified: no special handling of zero sign, overflow or subnormals beyond what the adder produces.
- `cnt` saturates at all-ones; it never wraps.
- `in_valid` low in IDLE or ACC causes no state change. Gaps inside a packet are allowed.
- No simultaneous in/out handshake: `in_ready` is 0 whenever `out_valid` is 1, so there is no bypass from OUT to a new packet in the same cycle.

## Timing
- Reset values: `in_ready`=0 while `reset` is asserted and 1 from the first clock edge after release (state IDLE). `out_valid`=0, `out_data`=0x00, `out_count`=0, `acc`=0, `cnt`=0.
- Throughput: one element per cycle.
- Latency: `out_valid` rises on the clock edge that accepts the `in_last` beat, i.e. one cycle after that handshake.
- After a take, `in_ready` returns to 1 in the next cycle, so there is a minimum of one idle cycle between packets.
- Reset mid-packet or mid-OUT: the partial sum and any pending result are discarded and the block returns to IDLE. Nothing is emitted for the aborted packet.
- `out_ready` may be held high permanently. `out_valid` then stays high for exactly one cycle per packet.

## Configuration
- `FLOAT_ACC_PIPE_EN` defined: adder operands are registered.
  - An accepted beat in ACC is captured into an operand register.
  - `in_ready` is 0 in the following cycle, while `acc` is updated from the registered operands.
  - Throughput is one element per 2 cycles in ACC. IDLE loads are unaffected.
  - If the captured beat was `in_last`, `out_valid` rises 2 cycles after its handshake.
  - Reset clears the operand register to 0.
- `FLOAT_ACC_PIPE_EN` undefined: behaviour exactly as described above.

## Test plan
- Packet 0x38, 0x38, 0x38 (last), with `out_ready`=1 → `out_data`=0x44 (3.0), `out_count`=3; `out_valid` high for one cycle, one cycle after the last beat.
- Single beat 0xC0 with `in_last` → `out_data`=0xC0 bit-exact, `out_count`=1.
- Packet 0x38, 0xB8 (last) → `out_data`=0x00, `out_count`=2.
- Packet 0x38, 0x38 (last) with `out_ready`=0 for 5 cycles → `out_valid`=1, `out_data`=0x40 and `out_count`=2 all stable, and `in_ready`=0 throughout. Take on cycle 6, then `in_ready`=1 the cycle after.
- `LEN_W`=2, five beats of 0x00, last on the fifth → `out_count`=3 (saturated), `out_data`=0x00.
- Assert `reset` after two beats of a packet, release, then send 0x40 (last) → result 0x40, count 1, no output for the aborted packet. With `FLOAT_ACC_PIPE_EN`, repeat scenario 1: `in_ready` alternates in ACC, and the result is 0x44 two cycles after the last beat.

Source files
------------

// File: rtl/float_acc_e4m3.sv
// float_acc_e4m3: streaming reduction of an e4m3 packet into one e4m3 sum plus element count.
// The adder rounds to nearest-even, saturates overflow to +/-448 (0x7E/0xFE) and returns 0x7F for a NaN operand.
// An exact cancellation gives +0. Negative zero results only from -0 + -0.
// Optional build macro FLOAT_ACC_PIPE_EN registers the adder operands.
// That mode accepts one element per two cycles in ACC.

module float_adder_e4m3 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);
    logic [17:0] ma, mb;
    logic [18:0] mag, rem, half;
    logic [4:0]  p, sh, ef;
    logic [3:0]  mr;
    logic [2:0]  kept;
    logic        s, up;

    function automatic logic [17:0] fixed(input logic [7:0] x);
        return 18'({|x[6:3], x[2:0]}) << ((x[6:3] == 4'd0) ? 4'd0 : x[6:3] - 4'd1);
    endfunction

    // exact signed-magnitude sum in 2^-9 units, then round-to-nearest-even back onto the e4m3 grid
    always_comb begin
        ma = fixed(a);
        mb = fixed(b);
        s = a[7];
        mag = {1'b0, ma} + {1'b0, mb};
        if (a[7] != b[7]) begin
            mag = (ma >= mb) ? {1'b0, ma - mb} : {1'b0, mb - ma};
            s = (ma > mb) ? a[7] : (ma < mb) ? b[7] : 1'b0;
        end
        p = 5'd0;
        for (int i = 0; i < 19; i++) if (mag[i]) p = 5'(i);
        sh = (p > 5'd3) ? p - 5'd3 : 5'd0;
        kept = 3'(mag >> sh);
        rem = mag & ((19'd1 << sh) - 19'd1);
        half = (sh == 5'd0) ? 19'd0 : 19'd1 << (sh - 5'd1);
        up = (sh != 5'd0) && ((rem > half) || (rem == half && kept[0]));
        mr = {1'b0, kept} + {3'd0, up};
        ef = mr[3] ? p - 5'd1 : p - 5'd2;
        if (a[6:0] == 7'h7F || b[6:0] == 7'h7F) y = 8'h7F;
        else if (mag < 19'd8) y = {s, 4'd0, mag[2:0]};
        else if (ef > 5'd15 || (ef == 5'd15 && mr[2:0] == 3'd7)) y = {s, 7'h7E};
        else y = {s, ef[3:0], mr[2:0]};
    end
endmodule

module float_acc_e4m3 #(
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [LEN_W-1:0] out_count
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t           state_q, state_d;
    logic [7:0]       acc_q, acc_d, add_b, sum;
    logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d, beat;
`ifdef FLOAT_ACC_PIPE_EN
    logic [7:0]       op_q, op_d;
    logic             last_q, last_d, pend_q, pend_d;

    assign add_b = op_q;
`else
    assign add_b = in_data;
`endif

    float_adder_e4m3 u_add (.a(acc_q), .b(add_b), .y(sum));

    assign beat      = in_valid && in_ready_q;
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_count = cnt_q;

    // packet FSM: first beat loads directly, later beats go through the adder, OUT holds until taken
    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
`ifdef FLOAT_ACC_PIPE_EN
        op_d = op_q;
        last_d = last_q;
        pend_d = pend_q;
`endif
        case (state_q)
            IDLE: if (beat) begin
                acc_d = in_data;
                cnt_d = LEN_W'(1);
                state_d = in_last ? OUT : ACC;
            end
            ACC: begin
`ifdef FLOAT_ACC_PIPE_EN
                if (pend_q) begin
                    acc_d = sum;
                    pend_d = 1'b0;
                    state_d = last_q ? OUT : ACC;
                end else if (beat) begin
                    op_d = in_data;
                    last_d = in_last;
                    pend_d = 1'b1;
                    cnt_d = cnt_inc;
                end
`else
                if (beat) begin
                    acc_d = sum;
                    cnt_d = cnt_inc;
                    state_d = in_last ? OUT : ACC;
                end
`endif
            end
            OUT: if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef FLOAT_ACC_PIPE_EN
        in_ready_d = (state_d != OUT) && !pend_d;
`else
        in_ready_d = state_d != OUT;
`endif
        out_valid_d = state_d == OUT;
    end

    // all state, including the registered handshake outputs, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q <= 8'd0;
            cnt_q <= '0;
            in_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef FLOAT_ACC_PIPE_EN
            op_q <= 8'd0;
            last_q <= 1'b0;
            pend_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            in_ready_q <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef FLOAT_ACC_PIPE_EN
            op_q <= op_d;
            last_q <= last_d;
            pend_q <= pend_d;
`endif
        end
    end
endmodule
